// File: rtl/riscv_mc_ctrl_if.sv
// Control bundle between the multicycle main controller and its datapath.
// The slave modport is the controller side, the master modport the datapath side.
interface riscv_mc_ctrl_if;
   logic [6:0] i_ctrl_opcode;
   logic [2:0] i_ctrl_funct3;
   logic       i_ctrl_funct7_5;
   logic       i_ctrl_alu_zero;
   logic       i_ctrl_mem_ready;
   logic       o_ctrl_mem_req;
   logic       o_ctrl_mem_wr_en;
   logic       o_ctrl_adr_src;
   logic       o_ctrl_ir_wr_en;
   logic       o_ctrl_pc_wr_en;
   logic       o_ctrl_reg_wr_en;
   logic [1:0] o_ctrl_src_alu_a;
   logic [1:0] o_ctrl_src_alu_b;
   logic [1:0] o_ctrl_src_rd;
   logic [2:0] o_ctrl_src_imm;
   logic [3:0] o_ctrl_alu_ctrl;
   logic       o_ctrl_illegal;
   logic [3:0] o_ctrl_state;

   modport slave (
      input  i_ctrl_opcode, i_ctrl_funct3, i_ctrl_funct7_5, i_ctrl_alu_zero, i_ctrl_mem_ready,
      output o_ctrl_mem_req, o_ctrl_mem_wr_en, o_ctrl_adr_src, o_ctrl_ir_wr_en,
             o_ctrl_pc_wr_en, o_ctrl_reg_wr_en, o_ctrl_src_alu_a, o_ctrl_src_alu_b,
             o_ctrl_src_rd, o_ctrl_src_imm, o_ctrl_alu_ctrl, o_ctrl_illegal, o_ctrl_state
   );

   modport master (
      output i_ctrl_opcode, i_ctrl_funct3, i_ctrl_funct7_5, i_ctrl_alu_zero, i_ctrl_mem_ready,
      input  o_ctrl_mem_req, o_ctrl_mem_wr_en, o_ctrl_adr_src, o_ctrl_ir_wr_en,
             o_ctrl_pc_wr_en, o_ctrl_reg_wr_en, o_ctrl_src_alu_a, o_ctrl_src_alu_b,
             o_ctrl_src_rd, o_ctrl_src_imm, o_ctrl_alu_ctrl, o_ctrl_illegal, o_ctrl_state
   );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// RV32I multicycle main controller: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port with ready-driven wait states.
module riscv_mc_ctrl (
   input  logic             i_clk,
   input  logic             i_rst,
   riscv_mc_ctrl_if.slave   bus
);
   localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11;
   localparam logic [3:0] S_JALR_LINK = 4'd12, S_LUI = 4'd13, S_AUIPC  = 4'd14, S_TRAP   = 4'd15;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9;

   logic [3:0] r_state;
   logic       r_illegal;
   logic [3:0] w_next;
   logic       w_req, w_wr, w_adr, w_ir, w_pc, w_reg;
   logic [1:0] w_a, w_b, w_rd;
   logic [2:0] w_imm;
   logic [3:0] w_alu, w_alu_op, w_alu_br;
   logic       w_taken;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP)
            r_illegal <= 1'b1;
      end
   end

   // Operation decode for R/I-type; only R-type turns funct7_5 into SUB.
   always_comb begin
      w_alu_op = ALU_ADD;
      case (bus.i_ctrl_funct3)
         3'b000: w_alu_op = (bus.i_ctrl_opcode == OP_R && bus.i_ctrl_funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001: w_alu_op = ALU_SLL;
         3'b010: w_alu_op = ALU_SLT;
         3'b011: w_alu_op = ALU_SLTU;
         3'b100: w_alu_op = ALU_XOR;
         3'b101: w_alu_op = bus.i_ctrl_funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110: w_alu_op = ALU_OR;
         3'b111: w_alu_op = ALU_AND;
      endcase
   end

   // Branch compares reduce to a zero test: funct3[0] and funct3[2] each invert the sense.
   always_comb begin
      case (bus.i_ctrl_funct3[2:1])
         2'b10:   w_alu_br = ALU_SLT;
         2'b11:   w_alu_br = ALU_SLTU;
         default: w_alu_br = ALU_SUB;
      endcase
   end
   assign w_taken = bus.i_ctrl_alu_zero ^ bus.i_ctrl_funct3[0] ^ bus.i_ctrl_funct3[2];

   always_comb begin
      case (bus.i_ctrl_opcode)
         OP_STORE:         w_imm = 3'b001;
         OP_BRANCH:        w_imm = 3'b010;
         OP_LUI, OP_AUIPC: w_imm = 3'b011;
         OP_JAL:           w_imm = 3'b100;
         default:          w_imm = 3'b000;
      endcase
   end

   always_comb begin
      w_next = r_state;
      w_req  = 1'b0;  w_wr  = 1'b0;  w_adr = 1'b0;
      w_ir   = 1'b0;  w_pc  = 1'b0;  w_reg = 1'b0;
      w_a    = 2'b00; w_b   = 2'b00; w_rd  = 2'b00;
      w_alu  = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            w_req = 1'b1; w_b = 2'b10; w_rd = 2'b10;
            if (bus.i_ctrl_mem_ready) begin
               w_ir = 1'b1; w_pc = 1'b1; w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            w_a = 2'b01; w_b = 2'b01;
            case (bus.i_ctrl_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:      w_next = S_EXEC_R;
               OP_I:      w_next = S_EXEC_I;
               OP_BRANCH: w_next = (bus.i_ctrl_funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
               OP_JAL:    w_next = S_JAL;
               OP_JALR:   w_next = S_JALR;
               OP_LUI:    w_next = S_LUI;
               OP_AUIPC:  w_next = S_AUIPC;
               default:   w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            w_a = 2'b10; w_b = 2'b01;
            w_next = (bus.i_ctrl_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_req = 1'b1; w_adr = 1'b1;
            if (bus.i_ctrl_mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_rd = 2'b01; w_reg = 1'b1; w_next = S_FETCH;
         end
         S_MEMWR: begin
            w_req = 1'b1; w_wr = 1'b1; w_adr = 1'b1;
            if (bus.i_ctrl_mem_ready) w_next = S_FETCH;
         end
         S_EXEC_R: begin
            w_a = 2'b10; w_alu = w_alu_op; w_next = S_ALUWB;
         end
         S_EXEC_I: begin
            w_a = 2'b10; w_b = 2'b01; w_alu = w_alu_op; w_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg = 1'b1; w_next = S_FETCH;
         end
         S_BRANCH: begin
            w_a = 2'b10; w_alu = w_alu_br; w_pc = w_taken; w_next = S_FETCH;
         end
         S_JAL: begin
            w_a = 2'b01; w_b = 2'b10; w_pc = 1'b1; w_next = S_ALUWB;
         end
         S_JALR: begin
            w_a = 2'b10; w_b = 2'b01; w_rd = 2'b10; w_pc = 1'b1; w_next = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            w_a = 2'b01; w_b = 2'b10; w_rd = 2'b10; w_reg = 1'b1; w_next = S_FETCH;
         end
         S_LUI: begin
            w_a = 2'b11; w_b = 2'b01; w_next = S_ALUWB;
         end
         S_AUIPC: begin
            w_a = 2'b01; w_b = 2'b01; w_next = S_ALUWB;
         end
         S_TRAP: w_next = S_TRAP;
      endcase
   end

   // Reset gates every strobe combinationally so nothing leaks out between edges.
   assign bus.o_ctrl_mem_req   = w_req & ~i_rst;
   assign bus.o_ctrl_mem_wr_en = w_wr  & ~i_rst;
   assign bus.o_ctrl_ir_wr_en  = w_ir  & ~i_rst;
   assign bus.o_ctrl_pc_wr_en  = w_pc  & ~i_rst;
   assign bus.o_ctrl_reg_wr_en = w_reg & ~i_rst;
   assign bus.o_ctrl_adr_src   = w_adr;
   assign bus.o_ctrl_src_alu_a = w_a;
   assign bus.o_ctrl_src_alu_b = w_b;
   assign bus.o_ctrl_src_rd    = w_rd;
   assign bus.o_ctrl_src_imm   = w_imm;
   assign bus.o_ctrl_alu_ctrl  = w_alu;
   assign bus.o_ctrl_illegal   = r_illegal;
   assign bus.o_ctrl_state     = r_state;
endmodule
